// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  // Transmit FSM states; PARITY is only visited when UART_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned tick_cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a word over valid/ready and shifts it out
// as start, data (LSB first), optional parity and stop bits. Bit timing comes
// only from the oversampling Tick input (OVERSAMPLE Ticks per bit).
// Optional parity bit: define UART_TX_PARITY_EN.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Tick,
  input  logic [DATA_BITS-1:0] TxData,
  input  logic                 TxValid,
`ifdef UART_TX_PARITY_EN
  input  logic                 ParityOdd,
`endif
  output logic                 TxReady,
  output logic                 Tx,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam int unsigned TickW = tick_cnt_width(OVERSAMPLE);
  localparam int unsigned BitW  = tick_cnt_width(DATA_BITS);

  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

  tx_state_t            r_state;
  logic [TickW-1:0]     r_tick_cnt;
  // Counts data bits in DATA and stop bits in STOP.
  logic [BitW-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0] r_shreg;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_bit_end;

  // Current serial bit finishes on this Tick.
  assign w_bit_end = Tick && (r_tick_cnt == TickLast);

  // Frame sequencer with registered line and handshake outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
      Tx         <= 1'b1;
      TxReady    <= 1'b1;
      TxBusy     <= 1'b0;
      TxDone     <= 1'b0;
    end else begin
      TxDone <= 1'b0;

      // Ticks are only counted inside a frame; the handshake cycle is IDLE, so
      // a Tick coinciding with it is dropped.
      if ((r_state != IDLE) && Tick) begin
        r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (TxValid && TxReady) begin
            r_shreg    <= TxData;
`ifdef UART_TX_PARITY_EN
            r_parity   <= (^TxData) ^ ParityOdd;
`endif
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= START;
            Tx         <= 1'b0;
            TxBusy     <= 1'b1;
            TxReady    <= 1'b0;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            Tx      <= r_shreg[0];
          end
        end

        DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == BitLast) begin
              r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= PARITY;
              Tx        <= r_parity;
`else
              r_state   <= STOP;
              Tx        <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shreg   <= r_shreg >> 1;
              Tx        <= r_shreg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            Tx      <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == StopLast) begin
              r_bit_cnt <= '0;
              r_state   <= IDLE;
              TxDone    <= 1'b1;
              TxBusy    <= 1'b0;
              TxReady   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          Tx      <= 1'b1;
          TxBusy  <= 1'b0;
          TxReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer. Build with UART_TX_PARITY_EN
// defined to also exercise the parity bit.
module tb_uart_tx_serializer;

  localparam int unsigned DB     = 8;
  localparam int unsigned OS     = 16;
  localparam int unsigned SB     = 1;
  localparam int          DIV    = 4;
  localparam int          BUDGET = 20000;

  logic          Clk;
  logic          Rst_n;
  logic          Tick;
  logic [DB-1:0] TxData;
  logic          TxValid;
  logic          ParityOdd;
  logic          TxReady;
  logic          Tx;
  logic          TxBusy;
  logic          TxDone;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   div;
  bit   tick_en;
  logic frame_bits[$];

  uart_tx_serializer #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .STOP_BITS (SB)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Tick     (Tick),
    .TxData   (TxData),
    .TxValid  (TxValid),
`ifdef UART_TX_PARITY_EN
    .ParityOdd(ParityOdd),
`endif
    .TxReady  (TxReady),
    .Tx       (Tx),
    .TxBusy   (TxBusy),
    .TxDone   (TxDone)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Baud generator stand-in: one Tick every DIV clocks, updated just after the edge.
  initial begin
    Tick = 1'b0;
    div  = 0;
    forever begin
      @(posedge Clk);
      #1;
      div  = (div + 1) % DIV;
      Tick = tick_en && (div == DIV - 1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop 1s.
  task automatic build_frame(input logic [DB-1:0] d, input logic par);
    frame_bits = {};
    frame_bits.push_back(1'b0);
    for (int i = 0; i < int'(DB); i++) frame_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    frame_bits.push_back((^d) ^ par);
`endif
    for (int i = 0; i < int'(SB); i++) frame_bits.push_back(1'b1);
  endtask

  // Present a word and return at the clock edge on which it was accepted.
  task automatic do_handshake(input logic [DB-1:0] d, input logic par, input bit align,
                              input string tag);
    bit rdy;
    bit got;
    if (align) begin
      // Make the handshake cycle coincide with a Tick.
      for (int i = 0; i < DIV && div != DIV - 2; i++) @(negedge Clk);
    end
    @(posedge Clk);
    #1;
    TxData    = d;
    ParityOdd = par;
    TxValid   = 1'b1;
    got       = 1'b0;
    for (int c = 0; c < BUDGET && !got; c++) begin
      @(negedge Clk);
      rdy = TxReady;
      @(posedge Clk);
      if (rdy) got = 1'b1;
    end
    if (!got) begin
      vec_cnt++;
      err_cnt++;
      $error("FAIL %s handshake timeout observed=0 expected=1", tag);
    end
  endtask

  // Follow one frame cycle by cycle from its handshake edge. Expected line
  // value is the frame bit selected by Ticks counted since the handshake.
  task automatic run_frame(input logic [DB-1:0] d, input logic par, input bit has_next,
                           input logic [DB-1:0] nd, input logic npar, input int abort_ticks,
                           input int stall_at, input string tag, output int done_cyc);
    int       ticks;
    int       cyc;
    int       total;
    int       stall_left;
    bit       stalled;
    bit       fin;
    logic [3:0] exp;
    build_frame(d, par);
    total      = frame_bits.size() * OS;
    ticks      = 0;
    cyc        = 0;
    stall_left = 0;
    stalled    = 1'b0;
    fin        = 1'b0;
    done_cyc   = -1;
    #1;
    if (has_next) begin
      TxData    = nd;
      ParityOdd = npar;
    end else begin
      TxValid = 1'b0;
    end
    while (!fin) begin
      @(negedge Clk);
      cyc++;
      if (cyc > BUDGET) begin
        vec_cnt++;
        err_cnt++;
        $error("FAIL %s frame timeout observed=%0d expected=%0d ticks", tag, ticks, total);
        fin = 1'b1;
      end else begin
        if (ticks >= total) begin
          exp      = 4'b1011;
          fin      = 1'b1;
          done_cyc = cyc;
        end else begin
          exp = {frame_bits[ticks / OS], 3'b100};
        end
        chk(tag, {28'd0, Tx, TxBusy, TxReady, TxDone}, {28'd0, exp});
        if (!fin) begin
          if (abort_ticks > 0 && ticks >= abort_ticks) fin = 1'b1;
          if (stall_at > 0 && !stalled && ticks == stall_at) begin
            stalled    = 1'b1;
            tick_en    = 1'b0;
            stall_left = 1000;
          end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) tick_en = 1'b1;
          end
          if (Tick) ticks++;
        end
      end
    end
  endtask

  initial begin
    int          dc;
    logic [DB-1:0] rd;
    logic        rp;

    Rst_n     = 1'b0;
    TxValid   = 1'b0;
    TxData    = '0;
    ParityOdd = 1'b0;
    tick_en   = 1'b1;

    // Reset state.
    #23;
    chk("reset", {28'd0, Tx, TxBusy, TxReady, TxDone}, 32'b1010);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;

    // 0xA5 with completion timing.
    do_handshake(8'hA5, 1'b0, 1'b0, "a5_hs");
    run_frame(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, "a5_frame", dc);
    chk("a5_done_window", {31'd0, (dc >= 636 && dc <= 644)}, 32'd1);

    // Back-to-back 0x00 then 0xFF with TxValid held high.
    do_handshake(8'h00, 1'b0, 1'b0, "b2b_hs");
    run_frame(8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 0, 0, "b2b_00", dc);
    @(posedge Clk);
    run_frame(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, "b2b_ff", dc);

    // Reset during data bit 3, then a clean 0x3C.
    do_handshake(8'hC3, 1'b0, 1'b0, "rst_hs");
    run_frame(8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 4 * OS + 8, 0, "rst_pre", dc);
    Rst_n = 1'b0;
    #1;
    chk("async_reset", {28'd0, Tx, TxBusy, TxReady, TxDone}, 32'b1010);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    do_handshake(8'h3C, 1'b0, 1'b0, "post_rst_hs");
    run_frame(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, "post_rst_3c", dc);

    // Handshake in the same cycle as a Tick.
    do_handshake(8'h55, 1'b0, 1'b1, "tick_hs");
    run_frame(8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, "tick_align_55", dc);

`ifdef UART_TX_PARITY_EN
    do_handshake(8'h07, 1'b0, 1'b0, "par_even_hs");
    run_frame(8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, "par_even_07", dc);
    do_handshake(8'h07, 1'b1, 1'b0, "par_odd_hs");
    run_frame(8'h07, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, "par_odd_07", dc);
`endif

    // Tick stuck low for 1000 cycles mid-frame.
    do_handshake(8'h96, 1'b0, 1'b0, "stall_hs");
    run_frame(8'h96, 1'b0, 1'b0, 8'h00, 1'b0, 0, 3 * OS + 5, "stall_96", dc);

    // Random words, parity and gaps.
    for (int i = 0; i < 6; i++) begin
      rd = DB'($urandom);
      rp = 1'($urandom);
      do_handshake(rd, rp, 1'($urandom), "rand_hs");
      run_frame(rd, rp, 1'b0, 8'h00, 1'b0, 0, 0, "rand_frame", dc);
      repeat ($urandom_range(0, 20)) @(negedge Clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream consumer of the baud tick generator.
- Takes a parallel byte through a valid/ready handshake and shifts it out on the serial line.
- Frame format: start bit, data bits LSB-first, optional parity, stop bit(s).
- Bit timing is derived only from the oversampling Tick pulse (OVERSAMPLE ticks per bit). The block has no divider of its own.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, Tick pulses per serial bit; legal range 2..64.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Tick  input  1  one-Clk-cycle oversampling pulse from the baud generator.
- TxData  input  DATA_BITS  byte to send; sampled on handshake.
- TxValid  input  1  TxData is valid.
- TxReady  output  1  block can accept a frame; high only in IDLE.
- Tx  output  1  serial line, registered; idles high.
- TxBusy  output  1  high from acceptance until the frame completes.
- TxDone  output  1  one-Clk-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset values: Tx=1, TxReady=1, TxBusy=0, TxDone=0. FSM=IDLE, all counters=0.
- Reset is asynchronous. If asserted mid-frame, Tx returns high at once and the frame is lost.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Handshake: a transfer occurs on the Clk edge where TxValid && TxReady.
  - TxData is latched into the shift register.
  - FSM goes to START. Tx=0 and TxBusy=1 from the next cycle.
  - TxReady drops the same next cycle.
  - TxValid while not ready is ignored. TxData need not be held after the handshake.
- Tick counter (width clog2(OVERSAMPLE)):
  - Cleared on the handshake.
  - Increments on each Tick while not IDLE.
  - A bit ends on the Tick where the count equals OVERSAMPLE-1; the counter wraps to 0 and the state or bit advances.
  - A Tick arriving in the handshake cycle is not counted.
  - Every bit therefore lasts exactly OVERSAMPLE Ticks, with first-bit jitter under one Tick period.
- DATA: shift register shifts right at each bit end; Tx = shreg[0]. Bit counter 0..DATA_BITS-1 selects the exit to PARITY or STOP.
- STOP: Tx=1 for STOP_BITS*OVERSAMPLE Ticks.
- Frame completion, on the final Tick:
  - TxDone pulses for one cycle.
  - TxBusy falls and TxReady rises in that same next-cycle output.
  - A new handshake is possible in the cycle TxReady is high, so frames can run back-to-back with no idle bit.
- If Tick is stuck low, the block holds its current state indefinitely. There is no timeout.
- Tx, TxReady, TxBusy and TxDone are all registered outputs with no combinational path from any input.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input ParityOdd (1 bit), sampled on the handshake.
  - Adds a PARITY state after DATA lasting OVERSAMPLE Ticks.
  - Tx = XOR of the data bits, inverted when ParityOdd=1.
- Undefined:
  - No ParityOdd port and no PARITY state.
  - DATA goes directly to STOP.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - default constants UART_DATA_BITS=8, UART_OVERSAMPLE=16;
  - a function computing the tick counter width.
- No sub-module; a single FSM plus counters. The baud generator is instantiated alongside this block at top level, not inside it.

Test Plan:
- Baud divider 4, so Tick every 4 Clk cycles and a 64-Clk bit. Send 0xA5.
  - Tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held for 64 Clk cycles.
  - TxDone pulses 640±4 cycles after the handshake.
- Hold TxValid high with 0x00 then 0xFF queued.
  - Second handshake occurs on the TxDone cycle.
  - No extra idle-high bits between the frames.
  - TxReady is low throughout each frame.
- Assert Rst_n=0 during data bit 3.
  - Tx=1, TxReady=1 and TxBusy=0 asynchronously.
  - After release, a new 0x3C frame sends correctly.
- Assert TxValid with 0x55 in the same cycle as a Tick.
  - Start bit lasts a full 16 Ticks, i.e. that Tick is not counted.
- With UART_TX_PARITY_EN and ParityOdd=0, send 0x07: parity bit = 1.
  - With ParityOdd=1: parity bit = 0.
  - Frame is 11 bits.
- Hold Tick low for 1000 cycles mid-frame.
  - Tx and state are frozen.
  - The frame resumes correctly when Tick restarts.
